// File: rtl/fetch_pkg.sv
// Shared types, widths and the constant jump-target table for the instruction fetch stage.
// Retarget absolute jumps by editing JUMP_TABLE; no fetch RTL changes needed.
package fetch_pkg;

  localparam int unsigned A         = 16;
  localparam int unsigned OFF_W     = 8;
  localparam int unsigned LUT_W     = 5;
  localparam int unsigned LUT_DEPTH = 1 << LUT_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [A-1:0] JUMP_TABLE [LUT_DEPTH] = '{
    16'h0000, 16'h0040, 16'h0080, 16'h0200, 16'h0100, 16'h0140, 16'h0180, 16'h01C0,
    16'h0300, 16'h0340, 16'h0380, 16'h03C0, 16'h0400, 16'h0440, 16'h0480, 16'h04C0,
    16'h0800, 16'h0840, 16'h0880, 16'h08C0, 16'h0900, 16'h0940, 16'h0980, 16'h09C0,
    16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h8000, 16'hC000, 16'hFF00, 16'hFFF0
  };

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage control/redirect and ROM-address bundle.
// InstCount is present only when INST_FETCH_PERF_CNT_EN is defined.
interface inst_fetch_if;
  import fetch_pkg::*;

  logic             Start;
  logic             Stall;
  logic             Halt;
  logic             BranchTaken;
  logic             BranchRel;
  logic [OFF_W-1:0] BranchOffset;
  logic [LUT_W-1:0] LutIndex;
  logic [A-1:0]     InstAddress;
  logic             Fetching;
  logic             Done;
`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0]      InstCount;
`endif

  // master drives control/redirects; slave is the fetch stage
  modport master (
    output Start, Stall, Halt, BranchTaken, BranchRel, BranchOffset, LutIndex,
    input  InstAddress, Fetching, Done
`ifdef INST_FETCH_PERF_CNT_EN
    , input InstCount
`endif
  );

  modport slave (
    input  Start, Stall, Halt, BranchTaken, BranchRel, BranchOffset, LutIndex,
    output InstAddress, Fetching, Done
`ifdef INST_FETCH_PERF_CNT_EN
    , output InstCount
`endif
  );

endinterface

// File: rtl/jump_lut.sv
// Combinational absolute-jump target lookup from the package table.
module jump_lut
  import fetch_pkg::*;
(
  input  logic [LUT_W-1:0] idx_i,
  output logic [A-1:0]     target_c
);

  assign target_c = JUMP_TABLE[idx_i];

endmodule

// File: rtl/inst_fetch.sv
// Program counter and fetch control: Start/Halt sequencing, increment, relative and LUT jumps.
// Optional retired-fetch counter on InstCount when INST_FETCH_PERF_CNT_EN is defined.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [A-1:0] START_ADDR = '0
) (
  input  logic         Clk,
  input  logic         Reset,
  inst_fetch_if.slave  bus
);

  fetch_state_t state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic         fetching_q, fetching_d;
  logic         done_q, done_d;
  logic         advance_c;
  logic         restart_c;
  logic [A-1:0] lut_target_c;
  logic [A-1:0] rel_target_c;

  jump_lut u_jump_lut (
    .idx_i    (bus.LutIndex),
    .target_c (lut_target_c)
  );

  // sign-extend the offset to PC width; the add wraps modulo 2**A
  assign rel_target_c = pc_q + {{(A-OFF_W){bus.BranchOffset[OFF_W-1]}}, bus.BranchOffset};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      fetching_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetching_q <= fetching_d;
      done_q     <= done_d;
    end
  end

  // priority in RUN: Start > Halt > Stall > BranchTaken > increment
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    advance_c = 1'b0;
    restart_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d   = RUN;
          pc_d      = START_ADDR;
          restart_c = 1'b1;
        end
      end
      RUN: begin
        if (bus.Start) begin
          pc_d      = START_ADDR;
          restart_c = 1'b1;
        end else if (bus.Halt) begin
          state_d = HALTED;
        end else if (!bus.Stall) begin
          advance_c = 1'b1;
          if (bus.BranchTaken) begin
            pc_d = bus.BranchRel ? rel_target_c : lut_target_c;
          end else begin
            pc_d = pc_q + A'(1);
          end
        end
      end
      HALTED: begin
        if (bus.Start) begin
          state_d   = RUN;
          pc_d      = START_ADDR;
          restart_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    fetching_d = (state_d == RUN);
    done_d     = (state_d == HALTED);
  end

  assign bus.InstAddress = pc_q;
  assign bus.Fetching    = fetching_q;
  assign bus.Done        = done_q;

`ifdef INST_FETCH_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // saturating count of PC advances/redirects; cleared by any accepted Start
  always_comb begin
    cnt_d = cnt_q;
    if (restart_c) begin
      cnt_d = '0;
    end else if (advance_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.InstCount = cnt_q;
`endif

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction ROM; drives the ROM address every cycle.
- Sequences a program: Start handshake, sequential increment, PC-relative branches, absolute jumps through a small target lookup table, halt with Done.
- Sits between the top-level testbench control (Start/Done) and the ROM, and takes redirect requests from decode/ALU.

Parameters:
- A, 16, PC / ROM address width.
- OFF_W, 8, width of signed relative branch offset.
- LUT_W, 5, jump-LUT index width (2**LUT_W entries).
- START_ADDR, 0, PC value loaded on Start.

Ports:
- Clk  input  1  clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  begin/restart program.
- Stall  input  1  hold PC this cycle.
- Halt  input  1  current instruction is halt.
- BranchTaken  input  1  redirect PC this cycle.
- BranchRel  input  1  1 = relative (PC+offset), 0 = absolute via LUT.
- BranchOffset  input  OFF_W  signed two's-complement offset.
- LutIndex  input  LUT_W  jump-target table index.
- InstAddress  output  A  PC, drives ROM address.
- Fetching  output  1  high in RUN; InstAddress is a live fetch.
- Done  output  1  high in HALTED.

Behaviour:
- States: IDLE, RUN, HALTED. Reset (Reset=0, asynchronous): state IDLE, InstAddress=0, Fetching=0, Done=0.
- Fetching and Done are decoded from registered state (no combinational path from inputs).
- IDLE: Start=1 -> RUN, PC<=START_ADDR. Other inputs ignored.
- RUN, per-edge priority: Start (PC<=START_ADDR, stay RUN) > Halt (->HALTED, PC holds) > Stall (PC holds) > BranchTaken > increment (PC<=PC+1).
- Stall takes priority over BranchTaken; the redirect is dropped. Decode must keep BranchTaken asserted until Stall deasserts.
- Relative target: PC + sign-extend(BranchOffset) to A bits, modulo 2**A.
- Absolute target: lut[LutIndex].
- Increment wraps 2**A-1 -> 0 silently.
- Latency: new PC is visible on InstAddress one cycle after the qualifying edge.
- ROM output is combinational, so the instruction at the new PC is valid in that same cycle.
- HALTED: PC frozen, Done=1. Start=1 -> RUN with PC<=START_ADDR and Done drops next cycle. Halt/Branch/Stall ignored.
- Reset asserted mid-RUN: immediate return to IDLE, InstAddress=0. The next run needs a fresh Start.

Optional Feature:
- Macro INST_FETCH_PERF_CNT_EN.
- Defined:
  - Adds output InstCount [31:0].
  - Cleared on Reset and on any accepted Start.
  - Increments on each RUN edge that advances or redirects PC. Not on Stall, Halt or Start cycles.
  - Saturates at 2**32-1.
  - Holds value in HALTED.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, HALTED}.
  - LUT_DEPTH localparam.
  - Constant jump-target table contents.
- Sub-module jump_lut (combinational, LutIndex -> A-bit target), reading its table from fetch_pkg so programs can retarget jumps without touching fetch RTL.

Test Plan:
- Reset=0 then 1, Start pulse 1 cycle -> InstAddress 0,0,1,2,3 on successive cycles; Fetching=1 from the cycle PC=0 is loaded.
- At PC=10, BranchTaken=1, BranchRel=1, BranchOffset=-4 (0xFC) -> next InstAddress=6. Repeat with +127 at PC=6 -> 133.
- lut[3]=0x0200; at PC=20, BranchTaken=1, BranchRel=0, LutIndex=3 -> InstAddress=0x0200.
- At PC=7, Stall=1 and BranchTaken=1 for 2 cycles -> PC stays 7. Then Stall=0 with BranchTaken held -> branch taken. Under INST_FETCH_PERF_CNT_EN, InstCount unchanged during the stall.
- Halt at PC=15 -> Done=1, PC holds 15 for 5 cycles despite BranchTaken. Start -> PC=0, Done=0 next cycle, InstCount=0.
- PC at 0xFFFF, no redirect -> wraps to 0x0000. Reset asserted mid-cycle -> InstAddress=0, state IDLE, without waiting for a clock edge.
